// File: rtl/sandbox_process_pipe.sv
// Host word pipeline: four-phase receive, LATENCY-stage transform, credit-guarded output FIFO.
// Receive back-pressure only by withholding clearDR; an LED blinks once per accepted word.
module sandbox_process_pipe #(
  parameter int DATA_WIDTH = 48,
  parameter int MODE       = 0,
  parameter int LATENCY    = 3,
  parameter int DEPTH      = 4,
  parameter int BLINK_MAX  = 7
) (
  input  logic                     masterClock,
  input  logic                     reset,
  input  logic                     slowClock,
  input  logic                     dataReceived,
  input  logic [DATA_WIDTH-1:0]    inputData,
  output logic                     clearDR,
  output logic                     transmitData,
  input  logic                     txAck,
  output logic [DATA_WIDTH-1:0]    outputData,
  output logic [$clog2(DEPTH):0]   fifoLevel,
  output logic                     busy,
  output logic                     rxIndicator
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 5;
  localparam int PW = $clog2(BLINK_MAX + 1);
  localparam int NB = DATA_WIDTH / 8;

  localparam logic [0:0] RX_IDLE = 1'b0;
  localparam logic [0:0] RX_HOLD = 1'b1;

  localparam logic [2:0] IND_OFF     = 3'd0;
  localparam logic [2:0] IND_WAIT_R1 = 3'd1;
  localparam logic [2:0] IND_WAIT_F1 = 3'd2;
  localparam logic [2:0] IND_WAIT_R2 = 3'd3;
  localparam logic [2:0] IND_WAIT_F2 = 3'd4;

  function automatic logic [DATA_WIDTH-1:0] xform(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r = d;
    if (MODE == 1) begin
      for (int i = 0; i < NB; i++) r[8*(NB-1-i) +: 8] = d[8*i +: 8];
    end else if (MODE == 2) begin
      r = d + DATA_WIDTH'(1);
    end
    return r;
  endfunction

  logic [0:0]            rx_state;
  logic                  accept;
  logic                  credit;
  logic [SW-1:0]         inflight;
  logic [DATA_WIDTH-1:0] pipe_dat [LATENCY];
  logic [LATENCY-1:0]    pipe_vld;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  wr_en;
  logic                  pop;
  logic [2:0]            slow_sync;
  logic                  slow_rise;
  logic                  slow_fall;
  logic [2:0]            ind_state;
  logic [PW-1:0]         pending;
  logic                  blink_done;

  // Credit counts words still in the pipe so the FIFO can never overflow.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + SW'(pipe_vld[i]);
  end

  assign credit = (SW'(count) + inflight) < SW'(DEPTH);
  assign accept = (rx_state == RX_IDLE) && dataReceived && credit;
  assign clearDR = (rx_state == RX_HOLD);

  always_ff @(posedge masterClock) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE: if (accept) rx_state <= RX_HOLD;
        RX_HOLD: if (!dataReceived) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge masterClock) begin
    if (!reset) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= accept;
      for (int i = 1; i < LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  always_ff @(posedge masterClock) begin
    if (accept) pipe_dat[0] <= xform(inputData);
    for (int i = 1; i < LATENCY; i++) pipe_dat[i] <= pipe_dat[i-1];
  end

  assign wr_en = pipe_vld[LATENCY-1];
  assign pop   = txAck && (count != '0);

  always_ff @(posedge masterClock) begin
    if (wr_en) mem[wr_ptr] <= pipe_dat[LATENCY-1];
  end

  always_ff @(posedge masterClock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign transmitData = (count != '0);
  assign outputData   = transmitData ? mem[rd_ptr] : '0;
  assign fifoLevel    = count;
  assign busy         = (rx_state != RX_IDLE) || (|pipe_vld) || transmitData;

  // Two sync flops plus one history flop for edge detection.
  always_ff @(posedge masterClock) begin
    if (!reset) slow_sync <= '0;
    else        slow_sync <= {slow_sync[1:0], slowClock};
  end

  assign slow_rise  = slow_sync[1] && !slow_sync[2];
  assign slow_fall  = !slow_sync[1] && slow_sync[2];
  assign blink_done = (ind_state == IND_WAIT_F2) && slow_fall;

  always_ff @(posedge masterClock) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      case ({accept, blink_done})
        2'b10:   if (pending != PW'(BLINK_MAX)) pending <= pending + PW'(1);
        2'b01:   pending <= pending - PW'(1);
        default: pending <= pending;
      endcase
    end
  end

  always_ff @(posedge masterClock) begin
    if (!reset) begin
      ind_state   <= IND_OFF;
      rxIndicator <= 1'b0;
    end else begin
      case (ind_state)
        IND_OFF:     if (pending != '0) ind_state <= IND_WAIT_R1;
        IND_WAIT_R1: if (slow_rise) ind_state <= IND_WAIT_F1;
        IND_WAIT_F1: if (slow_fall) begin
          rxIndicator <= 1'b1;
          ind_state   <= IND_WAIT_R2;
        end
        IND_WAIT_R2: if (slow_rise) ind_state <= IND_WAIT_F2;
        IND_WAIT_F2: if (slow_fall) begin
          rxIndicator <= 1'b0;
          ind_state   <= IND_OFF;
        end
        default:     ind_state <= IND_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_sandbox_process_pipe.sv
// Scoreboard bench: three instances (MODE 0/1/2) share stimulus; expected words queued at acceptance.
module tb_sandbox_process_pipe;

  localparam int DW = 48;

  logic          masterClock = 1'b0;
  logic          reset = 1'b0;
  logic          slowClock = 1'b0;
  logic          dataReceived = 1'b0;
  logic          txAck = 1'b0;
  logic [DW-1:0] inputData = '0;

  logic [2:0]    clr_v, tx_v, busy_v, ind_v;
  logic [DW-1:0] od [3];
  logic [2:0]    lvl [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sandbox_process_pipe #(.DATA_WIDTH(DW), .MODE(g), .LATENCY(3), .DEPTH(4), .BLINK_MAX(7)) dut (
      .masterClock (masterClock),
      .reset       (reset),
      .slowClock   (slowClock),
      .dataReceived(dataReceived),
      .inputData   (inputData),
      .clearDR     (clr_v[g]),
      .transmitData(tx_v[g]),
      .txAck       (txAck),
      .outputData  (od[g]),
      .fifoLevel   (lvl[g]),
      .busy        (busy_v[g]),
      .rxIndicator (ind_v[g])
    );
  end

  always #5 masterClock = ~masterClock;

  initial begin
    #3;
    forever #100 slowClock = ~slowClock;
  end

  int n_chk = 0;
  int n_pass = 0;
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  logic [DW-1:0] q2 [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] model(input int m, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (m == 1) for (int i = 0; i < DW/8; i++) r[8*(DW/8-1-i) +: 8] = d[8*i +: 8];
    if (m == 2) r = d + 48'd1;
    return r;
  endfunction

  task automatic tick();
    @(posedge masterClock);
    #1;
  endtask

  task automatic push_expect(input logic [DW-1:0] d);
    q0.push_back(model(0, d));
    q1.push_back(model(1, d));
    q2.push_back(model(2, d));
  endtask

  // Returns one cycle after the capture edge, with dataReceived already dropped.
  task automatic send_word(input logic [DW-1:0] d, input string tag);
    bit got;
    got = 1'b0;
    dataReceived = 1'b1;
    inputData = d;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (clr_v[0]) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_ack"}, 64'(got), 64'd1);
    if (got) push_expect(d);
    dataReceived = 1'b0;
    tick();
    check({tag, "_rel"}, 64'(clr_v[0]), 64'd0);
  endtask

  task automatic pop_word(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (tx_v[0]) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_tx"}, 64'(got), 64'd1);
    if (got) begin
      if (q0.size() == 0) check({tag, "_sb_empty"}, 64'd0, 64'd1);
      else begin
        check({tag, "_m0"}, 64'(od[0]), 64'(q0.pop_front()));
        check({tag, "_m1"}, 64'(od[1]), 64'(q1.pop_front()));
        check({tag, "_m2"}, 64'(od[2]), 64'(q2.pop_front()));
      end
      txAck = 1'b1;
      tick();
      txAck = 1'b0;
    end
  endtask

  // rxIndicator pulse monitor, sampled on the falling master edge.
  bit  mon_en = 1'b0;
  bit  ind_prev = 1'b0;
  int  pulses = 0, good_width = 0, bad_start = 0, cur_w = 0;
  time last_fall = 0;

  always @(negedge slowClock) last_fall = $time;

  always @(negedge masterClock) begin
    if (mon_en) begin
      if (ind_v[0] && !ind_prev) begin
        pulses++;
        if (($time - last_fall) < 20 || ($time - last_fall) > 40) bad_start++;
      end
      if (ind_v[0]) cur_w++;
      else if (ind_prev) begin
        if (cur_w == 20) good_width++;
        cur_w = 0;
      end
      ind_prev = ind_v[0];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    bit any_clr;

    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("reset_outs", {9'd0, clr_v[0], tx_v[0], od[0], lvl[0], busy_v[0], ind_v[0]}, 64'd0);
    end
    reset = 1'b1;
    tick();

    // Single word with exact latency.
    dataReceived = 1'b1;
    inputData = 48'h123456789ABC;
    tick();
    check("e0_clr", 64'(clr_v[0]), 64'd1);
    check("e0_tx", 64'(tx_v[0]), 64'd0);
    push_expect(48'h123456789ABC);
    dataReceived = 1'b0;
    tick();
    check("e1_clr", 64'(clr_v[0]), 64'd0);
    tick();
    check("e2_tx", 64'(tx_v[0]), 64'd0);
    tick();
    check("e3_tx", 64'(tx_v[0]), 64'd1);
    check("e3_lvl", 64'(lvl[0]), 64'd1);
    pop_word("single");
    check("single_lvl", 64'(lvl[0]), 64'd0);
    check("single_tx", 64'(tx_v[0]), 64'd0);

    // Back-pressure: fifth word must wait for a pop.
    for (int i = 0; i < 4; i++) send_word(48'hA00000000000 + 48'(i), "bp");
    repeat (4) tick();
    check("bp_full", 64'(lvl[0]), 64'd4);
    dataReceived = 1'b1;
    inputData = 48'hB0B0B0B0B0B5;
    any_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      any_clr |= clr_v[0];
    end
    check("bp_hold", 64'(any_clr), 64'd0);
    pop_word("bp_pop");
    k = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (clr_v[0]) begin
        k = 1;
        break;
      end
    end
    check("bp_ack5", 64'(k), 64'd1);
    if (k == 1) push_expect(48'hB0B0B0B0B0B5);
    dataReceived = 1'b0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (lvl[0] == 3'd4) begin
        k = i;
        break;
      end
    end
    check("bp_lat", 64'(k), 64'd3);
    for (int i = 0; i < 4; i++) pop_word("bp_drain");
    check("bp_empty", 64'(lvl[0]), 64'd0);

    // Write and pop on the same edge.
    send_word(48'h111111111111, "sim");
    send_word(48'h222222222222, "sim");
    repeat (4) tick();
    check("sim_lvl2", 64'(lvl[0]), 64'd2);
    send_word(48'h333333333333, "sim");
    tick();
    pop_word("sim_pop");
    check("sim_same_edge", 64'(lvl[0]), 64'd2);
    pop_word("sim_a");
    pop_word("sim_b");
    check("sim_empty", 64'(lvl[0]), 64'd0);

    // Transform corner cases, checked on all three instances.
    send_word(48'h010203040506, "xf");
    send_word(48'hFFFFFFFFFFFF, "xf");
    send_word(48'h00000000FFFF, "xf");
    for (int i = 0; i < 3; i++) pop_word("xf");

    txAck = 1'b1;
    tick();
    txAck = 1'b0;
    check("empty_ack_lvl", 64'(lvl[0]), 64'd0);
    check("empty_ack_tx", 64'(tx_v[0]), 64'd0);

    // Reset with two words queued and one in flight.
    send_word(48'h444444444444, "mid");
    send_word(48'h555555555555, "mid");
    repeat (4) tick();
    check("mid_lvl2", 64'(lvl[0]), 64'd2);
    send_word(48'h666666666666, "mid");
    reset = 1'b0;
    tick();
    tick();
    check("mid_rst", {59'd0, tx_v[0], lvl[0], busy_v[0]}, 64'd0);
    check("mid_rst_ind", 64'(ind_v[0]), 64'd0);
    reset = 1'b1;
    q0.delete();
    q1.delete();
    q2.delete();
    repeat (10) tick();
    check("mid_after", {12'd0, tx_v[0], lvl[0], od[0]}, 64'd0);
    check("mid_after_busy", 64'(busy_v[0]), 64'd0);

    // Two words inside one slowClock period give two full-period blinks.
    mon_en = 1'b1;
    send_word(48'h777777777777, "ind");
    send_word(48'h888888888888, "ind");
    pop_word("ind");
    pop_word("ind");
    repeat (200) tick();
    check("ind_pulses", 64'(pulses), 64'd2);
    check("ind_widths", 64'(good_width), 64'd2);
    check("ind_start", 64'(bad_start), 64'd0);
    check("ind_final", 64'(ind_v[0]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
